// File: rtl/sarray_out_deskew_if.sv
// Result-side bus of the systolic-array output deskew block: skewed rows in,
// aligned vectors out over valid/ready, plus status and sticky error flags.
interface sarray_out_deskew_if #(
    parameter int SARRAY_H   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) ();
    logic [SARRAY_H-1:0]            shin_valid_i;
    logic [SARRAY_H*DATA_WIDTH-1:0] shin_data_i;
    logic                           sho_valid_o;
    logic                           sho_ready_i;
    logic [SARRAY_H*DATA_WIDTH-1:0] sho_data_o;
    logic                           afull_o;
    logic [$clog2(DEPTH+1)-1:0]     cnt_o;
    logic                           err_ovf_o;
    logic                           err_align_o;
    logic                           err_clr_i;

    modport slave (
        input  shin_valid_i,
        input  shin_data_i,
        input  sho_ready_i,
        input  err_clr_i,
        output sho_valid_o,
        output sho_data_o,
        output afull_o,
        output cnt_o,
        output err_ovf_o,
        output err_align_o
    );

    modport master (
        output shin_valid_i,
        output shin_data_i,
        output sho_ready_i,
        output err_clr_i,
        input  sho_valid_o,
        input  sho_data_o,
        input  afull_o,
        input  cnt_o,
        input  err_ovf_o,
        input  err_align_o
    );
endinterface

// File: rtl/sarray_out_deskew.sv
// Re-aligns staggered systolic-array result rows (row i delayed SARRAY_H-1-i
// cycles) and buffers whole vectors in a show-ahead FIFO toward writeback.
module sarray_out_deskew #(
    parameter int SARRAY_H     = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 8,
    parameter int AFULL_MARGIN = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sarray_out_deskew_if.slave    bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int VW = SARRAY_H * DATA_WIDTH;

    logic [SARRAY_H-1:0] d_v;
    logic [VW-1:0]       d_data;

    genvar r;
    generate
        for (r = 0; r < SARRAY_H; r++) begin : g_row
            localparam int STAGES = SARRAY_H - 1 - r;
            if (STAGES == 0) begin : g_pass
                assign d_v[r]                            = bus.shin_valid_i[r];
                assign d_data[r*DATA_WIDTH +: DATA_WIDTH] = bus.shin_data_i[r*DATA_WIDTH +: DATA_WIDTH];
            end else begin : g_dly
                logic [STAGES-1:0]     v_q;
                logic [DATA_WIDTH-1:0] dat_q [STAGES];

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        v_q <= '0;
                    end else begin
                        v_q[0] <= bus.shin_valid_i[r];
                        for (int k = 1; k < STAGES; k++) begin
                            v_q[k] <= v_q[k-1];
                        end
                    end
                end

                // Row data is only meaningful alongside its valid bit, so it skips reset.
                always_ff @(posedge clk) begin
                    dat_q[0] <= bus.shin_data_i[r*DATA_WIDTH +: DATA_WIDTH];
                    for (int k = 1; k < STAGES; k++) begin
                        dat_q[k] <= dat_q[k-1];
                    end
                end

                assign d_v[r]                            = v_q[STAGES-1];
                assign d_data[r*DATA_WIDTH +: DATA_WIDTH] = dat_q[STAGES-1];
            end
        end
    endgenerate

    logic          all_v;
    logic          any_v;
    logic          push;
    logic          misalign;
    logic          full;
    logic          sho_valid;
    logic          pop;
    logic          wr_en;
    logic          drop;

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] wr_ptr_d;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_ptr_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          afull_q;
    logic          afull_d;
    logic          err_ovf_q;
    logic          err_ovf_d;
    logic          err_align_q;
    logic          err_align_d;
    logic [VW-1:0] mem_q [DEPTH];

    assign all_v     = &d_v;
    assign any_v     = |d_v;
    assign push      = all_v;
    assign misalign  = any_v & ~all_v;
    assign full      = (count_q == CW'(DEPTH));
    assign sho_valid = (count_q != '0);
    assign pop       = sho_valid & bus.sho_ready_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr_en     = push & (~full | pop);
    assign drop      = push & full & ~pop;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        afull_d     = 1'b0;
        err_ovf_d   = err_ovf_q;
        err_align_d = err_align_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        afull_d = ((DEPTH - int'(count_d)) <= AFULL_MARGIN);

        // A fresh error in the clearing cycle must survive the clear.
        if (bus.err_clr_i) begin
            err_ovf_d   = 1'b0;
            err_align_d = 1'b0;
        end
        if (drop) begin
            err_ovf_d = 1'b1;
        end
        if (misalign) begin
            err_align_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            afull_q     <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_align_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            afull_q     <= afull_d;
            err_ovf_q   <= err_ovf_d;
            err_align_q <= err_align_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= d_data;
        end
    end

    assign bus.sho_valid_o = sho_valid;
    assign bus.sho_data_o  = mem_q[rd_ptr_q];
    assign bus.afull_o     = afull_q;
    assign bus.cnt_o       = count_q;
    assign bus.err_ovf_o   = err_ovf_q;
    assign bus.err_align_o = err_align_q;

endmodule

// File: doc/sarray_out_deskew.md
Name: sarray_out_deskew

Overview:
Output-side counterpart of the systolic-array input skew registers. Result rows leave the array staggered: row i is valid i cycles after row 0. This block delays row i by SARRAY_H-1-i cycles so all rows of one result vector line up. It then buffers the aligned vectors in a small FIFO and hands them to writeback over a valid/ready handshake.

Parameters:
SARRAY_H, 4, number of array rows / result lanes
DATA_WIDTH, 32, bits per row result
DEPTH, 8, FIFO entries (power of 2, >=2)
AFULL_MARGIN, 4, afull_o asserts when free entries <= AFULL_MARGIN

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
shin_valid_i  in  SARRAY_H  per-row result valid, skewed (row i lags row 0 by i cycles)
shin_data_i  in  SARRAY_H*DATA_WIDTH  per-row result, row i at [i*DATA_WIDTH +: DATA_WIDTH]
sho_valid_o  out  1  aligned vector available
sho_ready_i  in  1  consumer accepts vector this cycle
sho_data_o  out  SARRAY_H*DATA_WIDTH  aligned vector, same row packing as input
afull_o  out  1  back-pressure hint to array issue logic
cnt_o  out  $clog2(DEPTH+1)  FIFO occupancy
err_ovf_o  out  1  sticky: aligned vector dropped because FIFO was full
err_align_o  out  1  sticky: rows of one aligned slot disagreed on valid
err_clr_i  in  1  synchronous clear of both sticky errors

Behaviour:
- Reset is asynchronous and active-low. It clears to 0: all delay-line valid bits, FIFO read/write pointers, count, sho_valid_o, afull_o, cnt_o, err_ovf_o and err_align_o. Delay-line and FIFO data are not reset. sho_data_o is don't-care while sho_valid_o=0.
- Delay lines: row i has SARRAY_H-1-i register stages, clocked every cycle with no enable. Row SARRAY_H-1 has zero stages (passes straight through). Valid and data travel together.
- Aligned valids d_v[i]. all_v = AND(d_v). any_v = OR(d_v).
- push = all_v. If any_v & ~all_v, the slot is discarded, nothing is pushed, and err_align_o is set.
- pop = sho_valid_o & sho_ready_i.
- FIFO is show-ahead. sho_valid_o = (count != 0). sho_data_o = entry at read pointer.
- Pointers wrap modulo DEPTH. count = pushes minus pops.
- Push while full with a simultaneous pop: accepted, count unchanged.
- Push while full with no pop: vector dropped, err_ovf_o set, FIFO state unchanged.
- Pop while empty is impossible, because pop requires sho_valid_o.
- Push and pop on an empty FIFO: the push is written and sho_valid_o rises next cycle. No combinational bypass.
- Latency: row SARRAY_H-1 valid at edge t puts the vector on sho_data_o with sho_valid_o=1 after edge t, i.e. in cycle t+1. Row 0 of the same vector entered SARRAY_H-1 cycles earlier.
- Throughput: one vector per cycle in and out.
- afull_o = registered (DEPTH - count_next <= AFULL_MARGIN).
- cnt_o = count, registered.
- Sticky errors hold until err_clr_i or reset. If err_clr_i and a new error occur in the same cycle, the error wins and the bit stays 1.
- The array cannot stall. The delay lines never back-pressure; only the FIFO drops.
- Reset mid-operation: in-flight skewed rows and buffered vectors are lost. No output vector appears until a complete new skewed set arrives.

Test Plan:
1. Skew in, align out: SARRAY_H=4. Row i valid at cycle 10+i with data 0x100*(i+1)+k, sho_ready_i=1 -> sho_valid_o=1 at cycle 14 only, sho_data_o={0x400,0x300,0x200,0x100}, cnt_o returns to 0 at cycle 15.
2. Back-to-back streaming: 20 consecutive skewed vectors, ready=1 -> 20 consecutive output cycles in order, cnt_o<=1, no errors.
3. Fill and overflow: ready=0, 9 vectors -> cnt_o=8, afull_o=1 from count>=4, 9th dropped, err_ovf_o=1. Then ready=1 -> vectors 1..8 drain in order and sho_valid_o drops after the 8th.
4. Full with simultaneous push/pop: count=8, ready=1 while a new vector aligns -> accepted, cnt_o stays 8, err_ovf_o stays 0.
5. Alignment error: row 2 valid omitted for one vector -> no push, err_align_o=1. err_clr_i pulse -> err_align_o=0 next cycle.
6. Reset mid-stream: rst_n low with 3 buffered vectors and 2 half-skewed vectors -> sho_valid_o=0, cnt_o=0 and errors=0 immediately. No spurious output after release until a full new vector arrives.
